uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, 8N1, LSB first, the receive side of the team's UART link (pairs with uart_tx).
- Oversamples the asynchronous rx line, validates the start bit at mid-bit, samples data bits at bit centres and checks the stop bit.
- Presents each received byte on a valid/ready handshake with overrun and framing-error reporting.
- Sits between a board pin and the byte-level consumer (FIFO or command parser).

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s
OVERSAMPLE, 16, sample ticks per bit; even, >= 4

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
rx_in  input  1  asynchronous serial line, idle high
data_out  output  8  received byte, stable while data_valid = 1
data_valid  output  1  byte available; held until accepted
data_ready  input  1  consumer accepts byte when data_valid && data_ready
frame_err  output  1  one-clk pulse: stop bit sampled low
overrun  output  1  sticky: byte completed while data_valid still high; cleared on next accept
busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset values (async, active-high):
  - state = IDLE; data_out = 0; data_valid, frame_err, overrun, busy = 0.
  - Synchronizer flops = 1; tick counter, sample counter and bit counter = 0.
- Input synchronization:
  - rx_in passes through a 2-flop synchronizer (rx_s).
  - All decisions use rx_s only, which adds 2 clk of latency.
- Tick generator:
  - DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer-truncated; DIV must be >= 1 (elaboration-time check).
  - Free-running counter, width max(1, $clog2(DIV)), counts 0..DIV-1.
  - samp_tick is a one-clk pulse when the count wraps.
  - The counter runs continuously and is not resynchronized to the start edge.
- sample_cnt, width $clog2(OVERSAMPLE), advances only on samp_tick. States:
  - IDLE: busy = 0. On samp_tick with rx_s = 0 -> START, sample_cnt = 0, busy = 1.
  - START: on samp_tick sample_cnt increments. When sample_cnt reaches OVERSAMPLE/2-1:
    - rx_s = 0 -> DATA, sample_cnt = 0, bit_cnt = 0.
    - rx_s = 1 -> glitch (false start): back to IDLE, busy = 0, no flags.
  - DATA: every OVERSAMPLE ticks (sample_cnt = OVERSAMPLE-1), shift rx_s into shift_reg[7] with a right shift, so LSB arrives first. bit_cnt 0..7; after bit 7 -> STOP.
  - STOP: after OVERSAMPLE ticks, sample rx_s.
    - rx_s = 1: data_out <= shift_reg, data_valid <= 1; if data_valid was already 1 and not accepted this same clk, overrun <= 1 and data_out is overwritten with the new byte. -> IDLE.
    - rx_s = 0: frame_err pulses 1 clk, byte discarded, data_valid unchanged -> BREAK.
  - BREAK: busy = 1; wait for rx_s = 1 on samp_tick -> IDLE. A held-low line (break) produces exactly one frame_err.
- Handshake:
  - data_valid drops the clk after data_valid && data_ready; overrun clears on that same accept.
  - If an accept and a new byte's completion happen in the same clk, the new byte wins: data_valid stays 1 and overrun is not set.
  - data_ready is ignored when data_valid = 0.
- Latency: data_valid rises 1 clk after the stop-bit mid-sample samp_tick. That is about 9.5 bit periods + 2 clk + tick phase after the falling start edge.
- Reset mid-frame: immediate abort to reset values; a partial byte is never presented.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1. Adds a PARITY state between DATA and STOP that samples one extra bit at its centre.
  - Even parity is required: XOR of 8 data bits and the parity bit = 0.
  - Adds output port parity_err (1 bit), a one-clk pulse on mismatch, issued in the clk the parity bit is sampled.
  - On mismatch the byte is discarded and STOP is still checked (frame_err is still possible).
- Undefined: no PARITY state, no parity_err port; the frame is 8N1 exactly as above.

Test Plan:
Bench parameters for all cases: CLK_FREQ=1_600_000, BAUD_RATE=100_000, OVERSAMPLE=16, giving DIV=1 and 16 clk/bit. data_ready=1 unless stated.
- Send 0xA5 as a clean frame -> data_out=0xA5, data_valid high exactly 1 clk, frame_err=0, overrun=0; busy falls back to 0 in IDLE.
- Low glitch of 4 clk on the idle line -> no data_valid, busy pulses then returns to 0 within 10 clk, no frame_err.
- Send 0x3C with the stop bit forced 0, then the line high -> one frame_err pulse, no data_valid; a following 0x81 is received correctly.
- data_ready=0; send 0x11 then 0x22 -> data_out=0x22, data_valid=1, overrun=1. Raise data_ready 1 clk -> data_valid=0, overrun=0.
- Assert reset during bit 4 of 0xFF, release, then send 0x55 -> all outputs 0 during reset; only 0x55 is presented.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> accepted. 0x07 with parity bit 0 -> parity_err pulse, no data_valid.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled start validation, valid/ready output, overrun and framing-error flags.
// Optional 8E1 framing with a parity_err pulse when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SAMP_W = $clog2(OVERSAMPLE);

    if (DIV < 1) begin : g_div_check
        $error("uart_rx: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
        $error("uart_rx: OVERSAMPLE must be even and >= 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t              state, state_n;
    logic                rx_meta, rx_s;
    logic [TICK_W-1:0]   tick_cnt;
    logic                samp_tick;
    logic [SAMP_W-1:0]   sample_cnt, sample_cnt_n;
    logic [2:0]          bit_cnt, bit_cnt_n;
    logic [7:0]          shift_reg, shift_n;
    logic [7:0]          data_out_n;
    logic                data_valid_n, overrun_n, frame_err_n, busy_n;
    logic                full_bit_c, half_bit_c, byte_ok_c;
`ifdef UART_RX_PARITY_EN
    logic                parity_bad, parity_bad_n, parity_err_n;
    assign byte_ok_c = ~parity_bad;
`else
    assign byte_ok_c = 1'b1;
`endif

    // Two-flop synchronizer; the line idles high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // Free-running oversample tick, never realigned to the start edge
    assign samp_tick = (tick_cnt == TICK_W'(DIV - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          tick_cnt <= '0;
        else if (samp_tick) tick_cnt <= '0;
        else                tick_cnt <= tick_cnt + TICK_W'(1);
    end

    assign full_bit_c = (sample_cnt == SAMP_W'(OVERSAMPLE - 1));
    assign half_bit_c = (sample_cnt == SAMP_W'(OVERSAMPLE / 2 - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            sample_cnt <= sample_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift_reg  <= shift_n;
            data_out   <= data_out_n;
            data_valid <= data_valid_n;
            overrun    <= overrun_n;
            frame_err  <= frame_err_n;
            busy       <= busy_n;
`ifdef UART_RX_PARITY_EN
            parity_bad <= parity_bad_n;
            parity_err <= parity_err_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        sample_cnt_n = sample_cnt;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift_reg;
        data_out_n   = data_out;
        data_valid_n = data_valid;
        overrun_n    = overrun;
        frame_err_n  = 1'b0;
        busy_n       = busy;
`ifdef UART_RX_PARITY_EN
        parity_bad_n = parity_bad;
        parity_err_n = 1'b0;
`endif
        // Accept first, so a byte completing in the same clk overrides it
        if (data_valid && data_ready) begin
            data_valid_n = 1'b0;
            overrun_n    = 1'b0;
        end

        case (state)
            IDLE: begin
                if (samp_tick && !rx_s) begin
                    state_n      = START;
                    sample_cnt_n = '0;
                    busy_n       = 1'b1;
                end
            end
            START: begin
                if (samp_tick) begin
                    if (half_bit_c) begin
                        sample_cnt_n = '0;
                        if (!rx_s) begin
                            state_n   = DATA;
                            bit_cnt_n = '0;
                        end else begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + SAMP_W'(1);
                    end
                end
            end
            DATA: begin
                if (samp_tick) begin
                    if (full_bit_c) begin
                        sample_cnt_n = '0;
                        shift_n      = {rx_s, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + SAMP_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (samp_tick) begin
                    if (full_bit_c) begin
                        sample_cnt_n = '0;
                        parity_bad_n = (^shift_reg) ^ rx_s;
                        parity_err_n = (^shift_reg) ^ rx_s;
                        state_n      = STOP;
                    end else begin
                        sample_cnt_n = sample_cnt + SAMP_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (samp_tick) begin
                    if (full_bit_c) begin
                        sample_cnt_n = '0;
                        if (rx_s) begin
                            if (byte_ok_c) begin
                                data_out_n   = shift_reg;
                                data_valid_n = 1'b1;
                                if (data_valid && !data_ready) overrun_n = 1'b1;
                            end
                            state_n = IDLE;
                            busy_n  = 1'b0;
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = BREAK;
                        end
                    end else begin
                        sample_cnt_n = sample_cnt + SAMP_W'(1);
                    end
                end
            end
            BREAK: begin
                if (samp_tick && rx_s) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are built bit-by-bit from bytes and compared with a queue of expected bytes.
module tb_uart_rx;

    localparam int unsigned BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ  (1_600_000),
        .BAUD_RATE (100_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int v_cycles, fe_cnt, pe_cnt;
    bit busy_seen;
    logic [7:0] rx_q[$];

    // Observe DUT outputs on the falling edge
    always @(negedge clk) begin
        if (data_valid) v_cycles++;
        if (data_valid && data_ready) rx_q.push_back(data_out);
        if (frame_err) fe_cnt++;
        if (busy) busy_seen = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pe_cnt++;
`endif
    end

    task automatic clear_mon();
        v_cycles  = 0;
        fe_cnt    = 0;
        pe_cnt    = 0;
        busy_seen = 1'b0;
        rx_q.delete();
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    // Start, 8 data bits LSB first, optional even parity, stop
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_bit);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_in = 1'b1; data_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_valid); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data_out); end
        checks++; if ({frame_err, overrun, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {frame_err, overrun, busy}); end
        reset = 1'b0;
        idle_bits(1);
    endtask

    task automatic test_clean();
        clear_mon();
        send_frame(8'hA5, 1'b1);
        idle_bits(2);
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL clean_count got %0d want 1", rx_q.size()); end
        else begin
            checks++; if (rx_q[0] !== 8'hA5) begin errors++; $display("FAIL clean_data got %h want a5", rx_q[0]); end
        end
        checks++; if (v_cycles !== 1) begin errors++; $display("FAIL clean_valid_cycles got %0d want 1", v_cycles); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL clean_frame_err got %0d want 0", fe_cnt); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clean_overrun got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen got %b want 1", busy_seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b want 0", busy); end
        idle_bits(2);
        checks++; if ({v_cycles, fe_cnt} !== {32'd0, 32'd0}) begin errors++; $display("FAIL glitch_events got valid=%0d fe=%0d want 0 0", v_cycles, fe_cnt); end
    endtask

    task automatic test_framing();
        clear_mon();
        send_frame(8'h3C, 1'b0);
        idle_bits(2);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL framing_fe got %0d want 1", fe_cnt); end
        checks++; if (v_cycles !== 0) begin errors++; $display("FAIL framing_valid got %0d want 0", v_cycles); end
        send_frame(8'h81, 1'b1);
        idle_bits(2);
        checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h81) begin errors++; $display("FAIL framing_next got n=%0d d=%h want n=1 d=81", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
        // Line held low for many frames gives a single framing error
        clear_mon();
        rx_in = 1'b0;
        repeat (30 * BIT_CLKS) @(negedge clk);
        idle_bits(2);
        checks++; if (fe_cnt !== 1 || v_cycles !== 0) begin errors++; $display("FAIL break_events got fe=%0d valid=%0d want 1 0", fe_cnt, v_cycles); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_busy got %b want 0", busy); end
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b1);
        idle_bits(1);
        checks++; if ({data_valid, overrun, data_out} !== {2'b10, 8'h11}) begin errors++; $display("FAIL overrun_first got v=%b o=%b d=%h want 1 0 11", data_valid, overrun, data_out); end
        send_frame(8'h22, 1'b1);
        idle_bits(1);
        checks++; if (data_out !== 8'h22) begin errors++; $display("FAIL overrun_data got %h want 22", data_out); end
        checks++; if ({data_valid, overrun} !== 2'b11) begin errors++; $display("FAIL overrun_flags got %b want 11", {data_valid, overrun}); end
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
        checks++; if ({data_valid, overrun} !== 2'b00) begin errors++; $display("FAIL overrun_accept got %b want 00", {data_valid, overrun}); end
        data_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] ff = 8'hFF;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(ff[i]);
        rx_in = ff[4];
        repeat (BIT_CLKS / 2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({data_valid, frame_err, overrun, busy, data_out} !== 12'h000) begin errors++; $display("FAIL midreset_outputs got v=%b f=%b o=%b b=%b d=%h want all 0", data_valid, frame_err, overrun, busy, data_out); end
        reset = 1'b0;
        clear_mon();
        idle_bits(6);
        send_frame(8'h55, 1'b1);
        idle_bits(2);
        checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h55) begin errors++; $display("FAIL midreset_rx got n=%0d d=%h want n=1 d=55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
        checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL midreset_fe got %0d want 0", fe_cnt); end
    endtask

    // Reference model: good stop bits yield the byte in order, bad ones one framing error each
    task automatic test_random();
        logic [7:0] exp_q[$];
        int exp_fe = 0;
        clear_mon();
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d = 8'($urandom);
            logic good = ($urandom_range(0, 3) != 0);
            send_frame(d, good);
            idle_bits(int'($urandom_range(1, 3)));
            if (good) exp_q.push_back(d);
            else exp_fe++;
        end
        checks++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_byte%0d got %h want %h", i, rx_q[i], exp_q[i]); end
            end
        end
        checks++; if (fe_cnt !== exp_fe) begin errors++; $display("FAIL random_fe got %0d want %0d", fe_cnt, exp_fe); end
        checks++; if (v_cycles !== exp_q.size()) begin errors++; $display("FAIL random_valid_cycles got %0d want %0d", v_cycles, exp_q.size()); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        par_flip = 1'b0;
        clear_mon();
        send_frame(8'h07, 1'b1);
        idle_bits(2);
        checks++; if (rx_q.size() !== 1 || rx_q[0] !== 8'h07 || pe_cnt !== 0) begin errors++; $display("FAIL parity_good got n=%0d pe=%0d want n=1 pe=0", rx_q.size(), pe_cnt); end
        par_flip = 1'b1;
        clear_mon();
        send_frame(8'h07, 1'b1);
        idle_bits(2);
        checks++; if (pe_cnt !== 1) begin errors++; $display("FAIL parity_err got %0d want 1", pe_cnt); end
        checks++; if (v_cycles !== 0 || fe_cnt !== 0) begin errors++; $display("FAIL parity_discard got valid=%0d fe=%0d want 0 0", v_cycles, fe_cnt); end
        par_flip = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_clean();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_mid();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
